// File: rtl/int_div_unit_if.sv
// Request/response bundle between the execute stage and the divide unit.
// The core drives the request side; the divider returns status and Result.
interface int_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Result;

   modport master (
      output start, op, A, B,
      input  busy, done, Result
   );

   modport slave (
      input  start, op, A, B,
      output busy, done, Result
   );
endinterface

// File: rtl/int_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per clock,
// divide-by-zero and signed overflow resolved at issue without iterating.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; Result holds last completion
// S_CALC | one restoring step per edge, 32 steps total, busy=1
// S_DONE | one-cycle done pulse, Result valid; always returns to S_IDLE
module int_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic          CLK,
   input  logic          RST,
   int_div_unit_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0]       OP_DIV  = 2'b00;
   localparam logic [1:0]       OP_REM  = 2'b10;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [4:0]       CNT_END = 5'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic             a_neg_q, a_neg_d;
   logic             b_neg_q, b_neg_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic             is_signed;
   logic             a_neg_in, b_neg_in;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             div_zero, sgn_ovf, special;
   logic [WIDTH-1:0] special_res;

   logic [WIDTH+1:0] shifted, diff;
   logic             step_ok;
   logic [WIDTH:0]   step_rem;
   logic [WIDTH-1:0] step_quo;
   logic [WIDTH-1:0] quo_fix, rem_fix;
   logic             last_step;

   // Issue-time decode: magnitudes and the early-out cases
   always_comb begin
      is_signed = ~bus.op[0];
      a_neg_in  = is_signed & bus.A[WIDTH-1];
      b_neg_in  = is_signed & bus.B[WIDTH-1];
      a_mag     = a_neg_in ? -bus.A : bus.A;
      b_mag     = b_neg_in ? -bus.B : bus.B;
      div_zero  = (bus.B == '0);
      sgn_ovf   = is_signed && (bus.A == MIN_NEG) && (bus.B == '1);
      special   = div_zero | sgn_ovf;
      if (div_zero) begin
         special_res = bus.op[1] ? bus.A : '1;
      end else begin
         special_res = bus.op[1] ? '0 : MIN_NEG;
      end
   end

   // Rem MSB is always 0 between steps, so the top of the wide difference is the borrow
   always_comb begin
      shifted   = {rem_q, dvd_q[WIDTH-1]};
      diff      = shifted - {2'b00, dvs_q};
      step_ok   = ~diff[WIDTH+1];
      step_rem  = step_ok ? diff[WIDTH:0] : shifted[WIDTH:0];
      step_quo  = {dvd_q[WIDTH-2:0], step_ok};
      quo_fix   = ((op_q == OP_DIV) && (a_neg_q ^ b_neg_q)) ? -step_quo : step_quo;
      rem_fix   = ((op_q == OP_REM) && a_neg_q) ? -step_rem[WIDTH-1:0]
                                                 : step_rem[WIDTH-1:0];
      last_step = (cnt_q == CNT_END);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = special ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (last_step) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy   = (state_q == S_CALC);
      bus.done   = (state_q == S_DONE);
      bus.Result = result_q;
   end

   always_comb begin
      op_d     = op_q;
      a_neg_d  = a_neg_q;
      b_neg_d  = b_neg_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               op_d    = bus.op;
               a_neg_d = a_neg_in;
               b_neg_d = b_neg_in;
               dvd_d   = a_mag;
               dvs_d   = b_mag;
               rem_d   = '0;
               cnt_d   = '0;
               if (special) begin
                  result_d = special_res;
               end
            end
         end
         S_CALC: begin
            rem_d = step_rem;
            dvd_d = step_quo;
            cnt_d = cnt_q + 5'd1;
            if (last_step) begin
               result_d = op_q[1] ? rem_fix : quo_fix;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         op_q     <= '0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         op_q     <= op_d;
         a_neg_q  <= a_neg_d;
         b_neg_q  <= b_neg_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_int_div_unit.sv
// Directed and randomized checks of int_div_unit: results, latency, done pulse,
// ignored restarts, reset abort and Result hold.
module tb_int_div_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int_div_unit_if #(.WIDTH(32)) bus ();

   int_div_unit #(.WIDTH(32)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.slave)
   );

   int          n_chk = 0;
   int          n_bad = 0;
   logic [31:0] last_res;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = a;
      sb = b;
      if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return op[1] ? 32'h0 : 32'h8000_0000;
      case (op)
         2'b00:   return sa / sb;
         2'b01:   return a / b;
         2'b10:   return sa % sb;
         default: return a % b;
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit inject);
      int busy_n;
      int wait_n;
      bit seen;
      bit special;
      special = (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      @(negedge clk);
      chk({tag, "_hold"}, bus.Result, last_res);
      bus.start = 1'b1;
      bus.op    = op;
      bus.A     = a;
      bus.B     = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.A     = $urandom;
      bus.B     = $urandom;
      bus.op    = 2'($urandom_range(0, 3));
      busy_n = 0;
      wait_n = 0;
      seen   = 1'b0;
      while (!seen && wait_n < 40) begin
         if (bus.done) begin
            seen = 1'b1;
         end else begin
            if (bus.busy) busy_n++;
            if (inject && bus.busy && (busy_n == 5 || busy_n == 20)) begin
               bus.start = 1'b1;
               bus.A     = $urandom;
               bus.B     = $urandom_range(1, 50);
               bus.op    = 2'($urandom_range(0, 3));
            end else begin
               bus.start = 1'b0;
            end
            @(negedge clk);
            wait_n++;
         end
      end
      bus.start = 1'b0;
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      chk({tag, "_busy_cycles"}, busy_n, special ? 32'd0 : 32'd32);
      chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      chk({tag, "_result"}, bus.Result, exp);
      @(negedge clk);
      chk({tag, "_one_pulse"}, 32'(bus.done), 32'd0);
      chk({tag, "_result_after"}, bus.Result, exp);
      last_res = exp;
   endtask

   initial begin
      int done_n;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.A     = '0;
      bus.B     = '0;
      last_res  = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_result", bus.Result, 32'd0);
      rst = 1'b0;

      run_op("divu_100_7",  2'b01, 32'd100,        32'd7,          32'd14,         1'b0);
      run_op("remu_100_7",  2'b11, 32'd100,        32'd7,          32'd2,          1'b0);
      run_op("div_m7_2",    2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0);
      run_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0);
      run_op("rem_7_m2",    2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0);
      run_op("div_by0",     2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b0);
      run_op("remu_by0",    2'b11, 32'd5,          32'd0,          32'd5,          1'b0);
      run_op("div_ovf",     2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0);
      run_op("rem_ovf",     2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1'b0);
      run_op("divu_ovfops", 2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1'b0);
      run_op("divu_inject", 2'b01, 32'd1000,       32'd10,         32'd100,        1'b1);

      // Reset mid-operation: abort, clear Result, no done afterwards
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 2'b01;
      bus.A     = 32'd999;
      bus.B     = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_result", bus.Result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      done_n = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) done_n++;
      end
      chk("abort_no_done", done_n, 32'd0);
      last_res = 32'd0;
      run_op("after_rst", 2'b01, 32'd100, 32'd7, 32'd14, 1'b0);

      for (int i = 0; i < 2000; i++) begin
         logic [1:0]  rop;
         logic [31:0] ra;
         logic [31:0] rb;
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         case ($urandom_range(0, 9))
            0:       rb = 32'h0;
            1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2, 3:    rb = $urandom_range(1, 20);
            4:       rb = -32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         run_op("rnd", rop, ra, rb, ref_div(rop, ra, rb), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
